// File: rtl/exec_cc_64.sv
// exec_cc_64: Y86-64 execute-stage condition codes, Cnd evaluation and E/M pipeline register
module exec_cc_64 #(
  parameter int W = 64,
  parameter logic [3:0] RNONE = 4'hF,
  parameter logic [3:0] INOP = 4'h1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         e_valid,
  input  logic [3:0]   e_icode,
  input  logic [3:0]   e_ifun,
  input  logic [W-1:0] alu_result,
  input  logic         alu_overflow,
  input  logic         set_cc,
  input  logic         cancel_cc,
  input  logic [W-1:0] e_valA,
  input  logic [3:0]   e_dstE,
  input  logic         m_stall,
  input  logic         m_bubble,
  output logic         zf,
  output logic         sf,
  output logic         of,
  output logic         e_cnd,
  output logic         m_valid,
  output logic [3:0]   m_icode,
  output logic         m_cnd,
  output logic [W-1:0] m_valE,
  output logic [W-1:0] m_valA,
  output logic [3:0]   m_dstE
);
  logic zf_q, sf_q, of_q, zf_d, sf_d, of_d;
  logic m_valid_q, m_valid_d, m_cnd_q, m_cnd_d;
  logic [3:0] m_icode_q, m_icode_d, m_dste_q, m_dste_d;
  logic [W-1:0] m_vale_q, m_vale_d, m_vala_q, m_vala_d;
  logic cc_we, lt;
  logic [3:0] dste_g;
  always_comb begin
    cc_we = e_valid & set_cc & ~cancel_cc & ~m_stall;
    lt = sf_q ^ of_q;
    e_cnd = (e_ifun == 4'd0) ? 1'b1 :
            (e_ifun == 4'd1) ? (lt | zf_q) :
            (e_ifun == 4'd2) ? lt :
            (e_ifun == 4'd3) ? zf_q :
            (e_ifun == 4'd4) ? ~zf_q :
            (e_ifun == 4'd5) ? ~lt :
            (e_ifun == 4'd6) ? (~lt & ~zf_q) : 1'b0;
    // a not-taken cmov must not write its destination
    dste_g = (e_icode == 4'h2 && !e_cnd) ? RNONE : e_dstE;
    zf_d = cc_we ? (alu_result == '0) : zf_q;
    sf_d = cc_we ? alu_result[W-1] : sf_q;
    of_d = cc_we ? alu_overflow : of_q;
    m_valid_d = m_stall ? m_valid_q : m_bubble ? 1'b0 : e_valid;
    m_icode_d = m_stall ? m_icode_q : m_bubble ? INOP : e_icode;
    m_cnd_d = m_stall ? m_cnd_q : m_bubble ? 1'b0 : e_cnd;
    m_vale_d = m_stall ? m_vale_q : m_bubble ? '0 : alu_result;
    m_vala_d = m_stall ? m_vala_q : m_bubble ? '0 : e_valA;
    m_dste_d = m_stall ? m_dste_q : m_bubble ? RNONE : dste_g;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_q <= 1'b1;
      sf_q <= 1'b0;
      of_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_icode_q <= INOP;
      m_cnd_q <= 1'b0;
      m_vale_q <= '0;
      m_vala_q <= '0;
      m_dste_q <= RNONE;
    end else begin
      zf_q <= zf_d;
      sf_q <= sf_d;
      of_q <= of_d;
      m_valid_q <= m_valid_d;
      m_icode_q <= m_icode_d;
      m_cnd_q <= m_cnd_d;
      m_vale_q <= m_vale_d;
      m_vala_q <= m_vala_d;
      m_dste_q <= m_dste_d;
    end
  end
  assign zf = zf_q;
  assign sf = sf_q;
  assign of = of_q;
  assign m_valid = m_valid_q;
  assign m_icode = m_icode_q;
  assign m_cnd = m_cnd_q;
  assign m_valE = m_vale_q;
  assign m_valA = m_vala_q;
  assign m_dstE = m_dste_q;
endmodule
